// File: rtl/dsp_io_pkg.sv
// dsp_io_pkg: shared types and defaults for the DSP frame I/O sequencer.
// Holds the sequencer state enum, the default memory/data widths and the
// drain-credit helper used to throttle output-memory reads.
package dsp_io_pkg;

    localparam int DEF_DAW = 10;
    localparam int DEF_DWW = 36;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2
    } io_state_t;

    // Slots of the 2-entry output buffer that remain committed after this
    // cycle: samples already buffered plus the read in flight, minus the
    // sample leaving on this cycle's handshake.
    function automatic logic [2:0] credit_used(
        input logic [1:0] buffered,
        input logic       inflight,
        input logic       pop
    );
        credit_used = {1'b0, buffered} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/dsp_io_skid.sv
// dsp_io_skid: 2-entry output FIFO with valid/ready on both sides.
// The head entry is held in a register, so out_data stays stable while the
// consumer stalls.
module dsp_io_skid
    import dsp_io_pkg::*;
#(
    parameter int DWW = DEF_DWW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DWW-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DWW-1:0] out_data,
    output logic [1:0]     count
);

    logic [DWW-1:0] data_q [2];
    logic           wr_ptr_q;
    logic           rd_ptr_q;
    logic [1:0]     count_q;
    logic [1:0]     count_d;
    logic           push_s;
    logic           pop_s;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = data_q[rd_ptr_q];
    assign count     = count_q;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q[0] <= {DWW{1'b0}};
            data_q[1] <= {DWW{1'b0}};
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            count_q <= count_d;
            if (push_s) begin
                data_q[wr_ptr_q] <= in_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: rtl/dsp_frame_io.sv
// dsp_frame_io: frame sequencer between sample streams and a DSP core.
// COLLECT writes NIN input samples into data memory, RUN hands the memory
// to the DSP for RUN_CYCLES cycles (after a one-cycle dsp_start pulse),
// DRAIN reads NOUT results back out through a 2-entry FIFO.
// Optional: define DSP_FRAME_IO_COUNT_EN to add the 16-bit frame_count output.
module dsp_frame_io
    import dsp_io_pkg::*;
#(
    parameter int             DAW        = DEF_DAW,
    parameter int             DWW        = DEF_DWW,
    parameter int             NIN        = 8,
    parameter int             NOUT       = 8,
    parameter logic [DAW-1:0] IN_BASE    = 10'h000,
    parameter logic [DAW-1:0] OUT_BASE   = 10'h040,
    parameter int             RUN_CYCLES = 520
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DWW-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DWW-1:0] out_data,
    output logic [DAW-1:0] mem_addr,
    output logic [DWW-1:0] mem_wdata,
    output logic           mem_we,
    input  logic [DWW-1:0] mem_rdata,
    output logic           io_owns_mem,
    output logic           dsp_start,
`ifdef DSP_FRAME_IO_COUNT_EN
    output logic [15:0]    frame_count,
`endif
    output logic           busy
);

    // Sample indices go up to 64, so 7 bits cover both counters.
    localparam int              IDXW     = 7;
    localparam int              RCW      = $clog2(RUN_CYCLES + 1) + 1;
    localparam logic [IDXW-1:0] IN_LAST  = IDXW'(NIN - 1);
    localparam logic [IDXW-1:0] OUT_LAST = IDXW'(NOUT - 1);
    localparam logic [IDXW-1:0] OUT_NUM  = IDXW'(NOUT);
    localparam logic [RCW-1:0]  RUN_LAST = RCW'(RUN_CYCLES);

    io_state_t       state_q;
    logic [IDXW-1:0] idx_q;
    logic [RCW-1:0]  run_cnt_q;
    logic            dsp_start_q;
    logic [IDXW-1:0] rd_idx_q;
    logic [IDXW-1:0] out_cnt_q;
    logic            inflight_q;

    logic            accept_s;
    logic            pop_s;
    logic            rd_issue_s;
    logic            push_s;
    logic            skid_in_ready_s;
    logic [1:0]      skid_count_s;
    logic [2:0]      credit_s;

    // in_ready is held low while reset is asserted even though the state
    // already reads COLLECT.
    assign in_ready    = (state_q == COLLECT) && !reset;
    assign accept_s    = in_valid && in_ready;
    assign pop_s       = out_valid && out_ready;
    assign busy        = (state_q == RUN);
    assign io_owns_mem = (state_q != RUN);
    assign dsp_start   = dsp_start_q;

    // A read may go out when the FIFO will still have a free slot for it,
    // counting the sample that leaves this cycle; this sustains one output
    // per cycle with out_ready held high and never overfills the FIFO.
    assign credit_s   = credit_used(skid_count_s, inflight_q, pop_s);
    assign rd_issue_s = (state_q == DRAIN) && (rd_idx_q != OUT_NUM) && (credit_s < 3'd2);

    // Read data returns one cycle after the address; capture it then.
    assign push_s = inflight_q && skid_in_ready_s;

    // Shared memory port: input writes in COLLECT, output reads in DRAIN, zero otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {DAW{1'b0}};
        mem_wdata = {DWW{1'b0}};
        if (accept_s) begin
            mem_we    = 1'b1;
            mem_addr  = IN_BASE + DAW'(idx_q);
            mem_wdata = in_data;
        end else if (rd_issue_s) begin
            mem_addr  = OUT_BASE + DAW'(rd_idx_q);
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Frame sequencer: COLLECT -> RUN -> DRAIN -> COLLECT with its counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= COLLECT;
            idx_q       <= IDXW'(0);
            run_cnt_q   <= RCW'(0);
            dsp_start_q <= 1'b0;
            rd_idx_q    <= IDXW'(0);
            out_cnt_q   <= IDXW'(0);
            inflight_q  <= 1'b0;
        end else begin
            dsp_start_q <= 1'b0;
            inflight_q  <= rd_issue_s;
            case (state_q)
                COLLECT: begin
                    if (accept_s) begin
                        if (idx_q == IN_LAST) begin
                            idx_q     <= IDXW'(0);
                            run_cnt_q <= RCW'(0);
                            state_q   <= RUN;
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                        end
                    end
                end
                RUN: begin
                    // Count 0 is the entry cycle; the pulse lands on count 1,
                    // which is the first of the RUN_CYCLES counted cycles.
                    if (run_cnt_q == RCW'(0)) begin
                        dsp_start_q <= 1'b1;
                    end
                    if (run_cnt_q == RUN_LAST) begin
                        run_cnt_q <= RCW'(0);
                        rd_idx_q  <= IDXW'(0);
                        out_cnt_q <= IDXW'(0);
                        state_q   <= DRAIN;
                    end else begin
                        run_cnt_q <= run_cnt_q + RCW'(1);
                    end
                end
                DRAIN: begin
                    if (rd_issue_s) begin
                        rd_idx_q <= rd_idx_q + IDXW'(1);
                    end
                    if (pop_s) begin
                        if (out_cnt_q == OUT_LAST) begin
                            out_cnt_q <= IDXW'(0);
                            rd_idx_q  <= IDXW'(0);
                            state_q   <= COLLECT;
                        end else begin
                            out_cnt_q <= out_cnt_q + IDXW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    dsp_io_skid #(
        .DWW (DWW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push_s),
        .in_ready  (skid_in_ready_s),
        .in_data   (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (skid_count_s)
    );

`ifdef DSP_FRAME_IO_COUNT_EN
    logic        frame_done_s;
    logic [15:0] frame_count_q;

    assign frame_done_s = (state_q == DRAIN) && pop_s && (out_cnt_q == OUT_LAST);
    assign frame_count  = frame_count_q;

    // Completed-frame counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_q <= 16'd0;
        end else if (frame_done_s) begin
            frame_count_q <= frame_count_q + 16'd1;
        end else begin
            frame_count_q <= frame_count_q;
        end
    end
`endif

endmodule
